// File: rtl/water_flow_meter_pkg.sv
// water_dispenser_pkg: shared types and constants for the water dispenser blocks.
//   state_t           : FSM state encoding (IDLE=0, MEASURING=1, DONE=2, FAULT=3)
//   volume_t          : millilitre quantity, MEASURED_ML_WIDTH bits
//   target_is_valid() : true for a dispensable volume (1..MAXIMUM_VOLUME_IN_ML)
package water_dispenser_pkg;

    localparam int CLOCK_PERIOD_IN_NS   = 20;
    localparam int MAXIMUM_VOLUME_IN_ML = 9999;
    localparam int MEASURED_ML_WIDTH    = 14;
    localparam int PRESCALER_WIDTH      = 8;
    localparam int TIMEOUT_WIDTH        = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEASURING = 2'd1,
        DONE      = 2'd2,
        FAULT     = 2'd3
    } state_t;

    typedef logic [MEASURED_ML_WIDTH-1:0] volume_t;

    function automatic logic target_is_valid(input volume_t target);
        return (target != '0) && (target <= volume_t'(MAXIMUM_VOLUME_IN_ML));
    endfunction

endpackage

// File: rtl/water_flow_meter_if.sv
// water_flow_meter_if: control/status bundle between a dispenser controller and the flow meter.
//   master : drives start, target_ml, abort, flow_pulse; observes the meter status
//   slave  : the meter; observes the requests, drives valve_open, measured_ml, busy, done, fault, state
interface water_flow_meter_if;
    import water_dispenser_pkg::*;

    logic    start;
    volume_t target_ml;
    logic    abort;
    logic    flow_pulse;
    logic    valve_open;
    volume_t measured_ml;
    logic    busy;
    logic    done;
    logic    fault;
    state_t  state;

    modport master (
        output start, target_ml, abort, flow_pulse,
        input  valve_open, measured_ml, busy, done, fault, state
    );

    modport slave (
        input  start, target_ml, abort, flow_pulse,
        output valve_open, measured_ml, busy, done, fault, state
    );

endinterface

// File: rtl/flow_pulse_sync.sv
// flow_pulse_sync: brings the asynchronous flow-sensor pulse into the clock domain and strobes its rising edges.
//   clock                : system clock
//   reset                : asynchronous active-high reset
//   pulse_in             : raw sensor output, asynchronous to clock
//   rising_edge_detected : one-cycle strobe per accepted rising edge, high after the third edge that saw pulse_in high
module flow_pulse_sync (
    input  logic clock,
    input  logic reset,
    input  logic pulse_in,
    output logic rising_edge_detected
);

    logic meta;
    logic synced;
    logic previous;
    logic level;

    // level only follows synced once two consecutive samples agree, so a
    // single-cycle glitch in either direction never produces a strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta     <= 1'b0;
            synced   <= 1'b0;
            previous <= 1'b0;
            level    <= 1'b0;
        end else begin
            meta     <= pulse_in;
            synced   <= meta;
            previous <= synced;
            if (synced == previous)
                level <= synced;
        end
    end

    assign rising_edge_detected = synced & previous & ~level;

endmodule

// File: rtl/water_flow_meter.sv
// water_flow_meter: meters a requested volume by counting flow-sensor pulses and drives the dispense valve.
//   clock : system clock (20 ns)
//   reset : asynchronous active-high reset, closes the valve immediately
//   bus   : slave side of water_flow_meter_if (start/target_ml/abort/flow_pulse in;
//           valve_open/measured_ml/busy/done/fault/state out, all registered)
module water_flow_meter
    import water_dispenser_pkg::*;
#(
    parameter int PULSES_PER_ML  = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input logic               clock,
    input logic               reset,
    water_flow_meter_if.slave bus
);

    localparam logic [PRESCALER_WIDTH-1:0] PRESCALER_LAST = PRESCALER_WIDTH'(PULSES_PER_ML - 1);
    localparam logic [TIMEOUT_WIDTH-1:0]   TIMEOUT_LAST   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic                       flow_edge;
    logic [PRESCALER_WIDTH-1:0] prescaler;
    logic [TIMEOUT_WIDTH-1:0]   timeout_count;
    volume_t                    target;
    volume_t                    next_ml;

    flow_pulse_sync u_sync (
        .clock                (clock),
        .reset                (reset),
        .pulse_in             (bus.flow_pulse),
        .rising_edge_detected (flow_edge)
    );

    assign next_ml = bus.measured_ml + volume_t'(1);

    // Status outputs are written alongside every state change so they always
    // reflect the state register and never depend combinationally on inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.state       <= IDLE;
            bus.measured_ml <= '0;
            bus.valve_open  <= 1'b0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.fault       <= 1'b0;
            target          <= '0;
            prescaler       <= '0;
            timeout_count   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (bus.state)
                IDLE: begin
                    if (bus.start && target_is_valid(bus.target_ml)) begin
                        target          <= bus.target_ml;
                        bus.measured_ml <= '0;
                        prescaler       <= '0;
                        timeout_count   <= '0;
                        bus.state       <= MEASURING;
                        bus.valve_open  <= 1'b1;
                        bus.busy        <= 1'b1;
                    end
                end
                MEASURING: begin
                    if (bus.abort) begin
                        bus.state      <= IDLE;
                        bus.valve_open <= 1'b0;
                        bus.busy       <= 1'b0;
                    end else if (flow_edge) begin
                        timeout_count <= '0;
                        if (prescaler == PRESCALER_LAST) begin
                            prescaler       <= '0;
                            bus.measured_ml <= next_ml;
                            if (next_ml == target) begin
                                bus.state      <= DONE;
                                bus.valve_open <= 1'b0;
                                bus.busy       <= 1'b0;
                                bus.done       <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + 1'b1;
                        end
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        bus.state      <= FAULT;
                        bus.valve_open <= 1'b0;
                        bus.busy       <= 1'b0;
                        bus.fault      <= 1'b1;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                DONE: begin
                    bus.state <= IDLE;
                end
                FAULT: begin
                    if (bus.abort) begin
                        bus.state <= IDLE;
                        bus.fault <= 1'b0;
                    end
                end
                default: begin
                    bus.state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_flow_meter.sv
// tb_water_flow_meter: randomized scoreboard bench for water_flow_meter with a volume-level reference model.
//   clock/reset : generated here; bus : water_flow_meter_if instance driven by the bench
module tb_water_flow_meter;
    import water_dispenser_pkg::*;

    localparam int PPM = 4;
    localparam int TMO = 100;

    typedef struct packed {
        state_t  st;
        logic    v;
        logic    b;
        logic    d;
        logic    f;
        volume_t ml;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    water_flow_meter_if bus ();

    water_flow_meter #(.PULSES_PER_ML(PPM), .TIMEOUT_CYCLES(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #(CLOCK_PERIOD_IN_NS / 2) clock = ~clock;

    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;
    obs_t   exp_q[$];
    state_t m_state  = IDLE;
    volume_t m_target = '0;
    volume_t m_ml     = '0;
    int     m_pulses = 0;

    function automatic obs_t mk(state_t st, logic v, logic b, logic d, logic f, volume_t ml);
        obs_t o;
        o.st = st; o.v = v; o.b = b; o.d = d; o.f = f; o.ml = ml;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(bus.state, bus.valve_open, bus.busy, bus.done, bus.fault, bus.measured_ml);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Every visible change of the status tuple must match the next predicted one.
    task automatic monitor();
        obs_t prev = mk(IDLE, 0, 0, 0, 0, '0);
        obs_t cur;
        obs_t e;
        forever begin
            @(negedge clock);
            if (mon_on) begin
                cur = sample();
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL obs_unexpected got st=%0d v=%0b b=%0b d=%0b f=%0b ml=%0d required no change",
                                 cur.st, cur.v, cur.b, cur.d, cur.f, cur.ml);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL obs_seq got st=%0d v=%0b b=%0b d=%0b f=%0b ml=%0d required st=%0d v=%0b b=%0b d=%0b f=%0b ml=%0d",
                                     cur.st, cur.v, cur.b, cur.d, cur.f, cur.ml, e.st, e.v, e.b, e.d, e.f, e.ml);
                        end
                    end
                    prev = cur;
                end
            end
        end
    endtask

    task automatic do_start(input volume_t t);
        if (m_state == IDLE && t >= 1 && t <= 9999) begin
            m_state = MEASURING; m_target = t; m_pulses = 0; m_ml = '0;
            exp_q.push_back(mk(MEASURING, 1, 1, 0, 0, '0));
        end
        @(negedge clock);
        bus.start = 1'b1;
        bus.target_ml = t;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic do_abort();
        if (m_state == MEASURING || m_state == FAULT) begin
            m_state = IDLE;
            exp_q.push_back(mk(IDLE, 0, 0, 0, 0, m_ml));
        end
        @(negedge clock);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
    endtask

    // A pulse counts only if it lasts at least two cycles and arrives while measuring.
    task automatic pulse(input int hi, input int lo);
        if (m_state == MEASURING && hi >= 2) begin
            m_pulses++;
            if (m_pulses % PPM == 0) begin
                m_ml++;
                if (m_ml == m_target) begin
                    exp_q.push_back(mk(DONE, 0, 0, 1, 0, m_ml));
                    exp_q.push_back(mk(IDLE, 0, 0, 0, 0, m_ml));
                    m_state = IDLE;
                end else begin
                    exp_q.push_back(mk(MEASURING, 1, 1, 0, 0, m_ml));
                end
            end
        end
        @(negedge clock);
        bus.flow_pulse = 1'b1;
        repeat (hi) @(negedge clock);
        bus.flow_pulse = 1'b0;
        repeat (lo) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.target_ml = '0;
        bus.abort = 1'b0;
        bus.flow_pulse = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clock);
        chk("reset_state", 32'(bus.state), 32'(IDLE));
        chk("reset_valve", 32'(bus.valve_open), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_fault", 32'(bus.fault), 0);
        chk("reset_ml", 32'(bus.measured_ml), 0);
        reset = 1'b0;
        mon_on = 1'b1;
        @(negedge clock);

        // target 3, twelve clean pulses, a thirteenth that must be ignored
        do_start(14'd3);
        for (int k = 0; k < 13; k++) pulse(4, 4);
        chk("after_13th_ml", 32'(bus.measured_ml), 3);
        chk("after_13th_state", 32'(bus.state), 32'(IDLE));

        // out-of-range targets are ignored
        do_start(14'd0);
        do_start(14'd10000);
        repeat (3) @(negedge clock);
        chk("bad_target_state", 32'(bus.state), 32'(IDLE));
        chk("bad_target_valve", 32'(bus.valve_open), 0);
        chk("bad_target_ml", 32'(bus.measured_ml), 3);

        // timeout into FAULT, start ignored, abort clears
        do_start(14'd5);
        for (int k = 0; k < 8; k++) pulse(4, 4);
        exp_q.push_back(mk(FAULT, 0, 0, 0, 1, 14'd2));
        m_state = FAULT;
        repeat (100) @(negedge clock);
        chk("timeout_fault", 32'(bus.fault), 1);
        chk("timeout_valve", 32'(bus.valve_open), 0);
        chk("timeout_ml", 32'(bus.measured_ml), 2);
        do_start(14'd3);
        chk("fault_start_ignored", 32'(bus.state), 32'(FAULT));
        do_abort();
        chk("fault_cleared", 32'(bus.fault), 0);
        chk("fault_abort_state", 32'(bus.state), 32'(IDLE));

        // abort lands on the same edge as the completing strobe
        do_start(14'd1);
        for (int k = 0; k < 3; k++) pulse(4, 4);
        m_state = IDLE;
        exp_q.push_back(mk(IDLE, 0, 0, 0, 0, '0));
        @(negedge clock);
        bus.flow_pulse = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        repeat (3) @(negedge clock);
        bus.flow_pulse = 1'b0;
        repeat (5) @(negedge clock);
        chk("abort_vs_done_ml", 32'(bus.measured_ml), 0);
        chk("abort_vs_done_state", 32'(bus.state), 32'(IDLE));

        // single-cycle glitch must not advance the prescaler
        do_start(14'd2);
        for (int k = 0; k < 3; k++) pulse(4, 4);
        pulse(1, 4);
        for (int k = 0; k < 4; k++) pulse(4, 4);
        chk("glitch_ml", 32'(bus.measured_ml), 1);
        chk("glitch_state", 32'(bus.state), 32'(MEASURING));
        do_abort();

        // asynchronous reset mid-dispense
        do_start(14'd9);
        for (int k = 0; k < 6; k++) pulse(4, 4);
        @(posedge clock);
        #5;
        exp_q.push_back(mk(IDLE, 0, 0, 0, 0, '0));
        m_state = IDLE; m_ml = '0;
        reset = 1'b1;
        #1;
        chk("async_reset_valve", 32'(bus.valve_open), 0);
        chk("async_reset_busy", 32'(bus.busy), 0);
        chk("async_reset_state", 32'(bus.state), 32'(IDLE));
        chk("async_reset_ml", 32'(bus.measured_ml), 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // randomized dispenses with stray starts and aborts
        for (int it = 0; it < 15; it++) begin
            do_start(14'($urandom_range(1, 6)));
            n = int'($urandom_range(0, 4 * int'(m_target) + 3));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 7) == 0) do_start(14'($urandom_range(1, 9999)));
                pulse(int'($urandom_range(2, 4)), int'($urandom_range(3, 5)));
            end
            do_abort();
            do_start(14'($urandom_range(10000, 16383)));
            chk("rand_bad_target_state", 32'(bus.state), 32'(IDLE));
        end

        repeat (10) @(negedge clock);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
